rr_arbiter_n: RTL and testbench

Parametrised round-robin arbiter for the crossbar output ports. It replaces the fixed two-input arbiter and arbitrates N requesters with a rotating priority pointer. An optional lock mode holds a grant for a whole multi-cycle transfer. One instance sits in front of each crossbar output mux and drives its select with `grant_idx`.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_arbiter_n.sv | 96 +++++++++
 tb/tb_rr_arbiter_n.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: FSM state encoding, clog2 helper, requester limit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb_pkg;

   // Largest requester count an arbiter instance may be built with.
   localparam int N_MAX = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Ceiling log2, for sizing the encoded requester index.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first requester at or after ptr, searching cyclically.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever req and ptr are stable.
module rr_pick #(
   parameter int N    = 4,
   parameter int IDXW = 2
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic [IDXW-1:0] winner,
   output logic [N-1:0]    winner_oh,
   output logic            any
);

   int idx;

   // Walk ptr, ptr+1, ..., wrapping at N; the first set request wins.
   always_comb begin
      winner    = '0;
      winner_oh = '0;
      any       = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!any && req[idx]) begin
            any            = 1'b1;
            winner         = IDXW'(idx);
            winner_oh[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with optional grant lock for multi-cycle transfers.
// Latency: one cycle from req to registered grant when idle or releasing.
// Backpressure: none; requesters keep req asserted until granted.
module rr_arbiter_n
   import arb_pkg::*;
#(
   parameter  int N    = 4,
   parameter  int LOCK = 1,
   localparam int IDXW = clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    last,
   output logic [N-1:0]    grant,
   output logic            grant_valid,
   output logic [IDXW-1:0] grant_idx
);

   if (N < 2 || N > N_MAX) begin : g_bad_n
      $error("rr_arbiter_n: N must lie in 2..16");
   end

   state_t          state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] owner_q, owner_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [IDXW-1:0] grant_idx_q, grant_idx_d;
   logic            grant_valid_q, grant_valid_d;

   logic [IDXW-1:0] pick_idx;
   logic [N-1:0]    pick_oh;
   logic            pick_any;
   logic            owner_rel;

   rr_pick #(
      .N    (N),
      .IDXW (IDXW)
   ) u_pick (
      .req       (req),
      .ptr       (ptr_q),
      .winner    (pick_idx),
      .winner_oh (pick_oh),
      .any       (pick_any)
   );

   // Decide hold vs. re-arbitrate; a release re-picks in the same edge so there is no idle bubble.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      grant_d       = grant_q;
      grant_idx_d   = grant_idx_q;
      grant_valid_d = grant_valid_q;
      owner_rel     = (LOCK == 0) || !req[owner_q] || last[owner_q];
      if (state_q == IDLE || owner_rel) begin
         if (pick_any) begin
            state_d       = BUSY;
            owner_d       = pick_idx;
            grant_d       = pick_oh;
            grant_idx_d   = pick_idx;
            grant_valid_d = 1'b1;
            // The winner drops to lowest priority; wrap explicitly so ptr stays below N.
            ptr_d         = (int'(pick_idx) == N - 1) ? '0 : pick_idx + IDXW'(1);
         end else begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
         end
      end
   end

   // State and output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         owner_q       <= '0;
         grant_q       <= '0;
         grant_idx_q   <= '0;
         grant_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         grant_q       <= grant_d;
         grant_idx_q   <= grant_idx_d;
         grant_valid_q <= grant_valid_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: four instances (N=4 free-running, N=4 locked, N=3, N=2).
// Latency: checks registered grant one cycle after the sampling edge.
// Backpressure: n/a.
module tb_rr_arbiter_n;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0] req_a, last_a, grant_a; logic gv_a; logic [1:0] idx_a;
   logic [3:0] req_b, last_b, grant_b; logic gv_b; logic [1:0] idx_b;
   logic [2:0] req_c, last_c, grant_c; logic gv_c; logic [1:0] idx_c;
   logic [1:0] req_d, last_d, grant_d; logic gv_d; logic       idx_d;

   rr_arbiter_n #(.N(4), .LOCK(0)) u_a (.clk(clk), .rst(rst), .req(req_a), .last(last_a),
      .grant(grant_a), .grant_valid(gv_a), .grant_idx(idx_a));
   rr_arbiter_n #(.N(4), .LOCK(1)) u_b (.clk(clk), .rst(rst), .req(req_b), .last(last_b),
      .grant(grant_b), .grant_valid(gv_b), .grant_idx(idx_b));
   rr_arbiter_n #(.N(3), .LOCK(0)) u_c (.clk(clk), .rst(rst), .req(req_c), .last(last_c),
      .grant(grant_c), .grant_valid(gv_c), .grant_idx(idx_c));
   rr_arbiter_n #(.N(2), .LOCK(0)) u_d (.clk(clk), .rst(rst), .req(req_d), .last(last_d),
      .grant(grant_d), .grant_valid(gv_d), .grant_idx(idx_d));

   // Reference: a transfer owner plus a "highest priority" requester number.
   typedef struct {
      int         n;
      bit         lock;
      bit         busy;
      int         ptr;
      int         owner;
      int         idx;
      logic [15:0] grant;
   } mdl_t;

   typedef struct {
      logic [3:0] req;
      logic [3:0] last;
      logic [3:0] g;
      int         idx;
   } vec_t;

   mdl_t m [4];
   vec_t tbl [16];
   int nvec = 0;
   int nerr = 0;

   function automatic mdl_t mdl_init(input int n, input bit lock);
      mdl_t r;
      r.n = n; r.lock = lock; r.busy = 0; r.ptr = 0; r.owner = 0; r.idx = 0; r.grant = '0;
      return r;
   endfunction

   // Winner = requesting i with the smallest cyclic distance (i - ptr) mod n.
   function automatic mdl_t mdl_step(input mdl_t mi, input logic [15:0] r, input logic [15:0] l);
      mdl_t mo;
      bit   rel;
      int   best, bd, d;
      mo  = mi;
      rel = !mi.busy || !mi.lock || !r[mi.owner] || l[mi.owner];
      if (rel) begin
         best = -1;
         bd   = 1000;
         for (int i = 0; i < mi.n; i++) begin
            d = (i - mi.ptr + mi.n) % mi.n;
            if (r[i] && d < bd) begin
               bd   = d;
               best = i;
            end
         end
         if (best < 0) begin
            mo.busy  = 0;
            mo.grant = '0;
         end else begin
            mo.busy  = 1;
            mo.owner = best;
            mo.idx   = best;
            mo.grant = 16'(1) << best;
            mo.ptr   = (best + 1) % mi.n;
         end
      end
      return mo;
   endfunction

   task automatic models_reset();
      m[0] = mdl_init(4, 0);
      m[1] = mdl_init(4, 1);
      m[2] = mdl_init(3, 0);
      m[3] = mdl_init(2, 0);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_one(input string nm, input mdl_t e, input logic [15:0] g,
                            input logic v, input logic [31:0] idx);
      check({nm, ".grant"}, 32'(g), 32'(e.grant));
      check({nm, ".valid"}, 32'(v), 32'(e.grant != 0));
      check({nm, ".idx"},   idx,    32'(e.idx));
   endtask

   task automatic compare_all();
      check_one("A", m[0], 16'(grant_a), gv_a, 32'(idx_a));
      check_one("B", m[1], 16'(grant_b), gv_b, 32'(idx_b));
      check_one("C", m[2], 16'(grant_c), gv_c, 32'(idx_c));
      check_one("D", m[3], 16'(grant_d), gv_d, 32'(idx_d));
   endtask

   // One clock: models consume the inputs sampled at the edge, outputs checked just after.
   task automatic tick();
      @(posedge clk);
      m[0] = mdl_step(m[0], 16'(req_a), 16'(last_a));
      m[1] = mdl_step(m[1], 16'(req_b), 16'(last_b));
      m[2] = mdl_step(m[2], 16'(req_c), 16'(last_c));
      m[3] = mdl_step(m[3], 16'(req_d), 16'(last_d));
      #1;
      compare_all();
   endtask

   task automatic all_idle();
      req_a = '0; last_a = '0; req_b = '0; last_b = '0;
      req_c = '0; last_c = '0; req_d = '0; last_d = '0;
   endtask

   initial begin
      // Locked-mode vectors for instance B, starting from reset (ptr=0, idle).
      tbl[0]  = '{4'b0101, 4'b0000, 4'b0001, 0};
      tbl[1]  = '{4'b0101, 4'b0000, 4'b0001, 0};
      tbl[2]  = '{4'b0101, 4'b0000, 4'b0001, 0};
      tbl[3]  = '{4'b0101, 4'b0001, 4'b0100, 2};  // last on owner: move with no bubble
      tbl[4]  = '{4'b0101, 4'b0000, 4'b0100, 2};
      tbl[5]  = '{4'b0101, 4'b0100, 4'b0001, 0};
      tbl[6]  = '{4'b0100, 4'b0000, 4'b0100, 2};  // owner drops req without last
      tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 2};  // release to idle, idx holds
      tbl[8]  = '{4'b0010, 4'b0010, 4'b0010, 1};
      tbl[9]  = '{4'b0010, 4'b0010, 4'b0010, 1};  // sole requester regranted
      tbl[10] = '{4'b0010, 4'b0010, 4'b0010, 1};
      tbl[11] = '{4'b1010, 4'b0000, 4'b0010, 1};
      tbl[12] = '{4'b1010, 4'b0010, 4'b1000, 3};
      tbl[13] = '{4'b0011, 4'b1000, 4'b0001, 0};  // req drop and last together
      tbl[14] = '{4'b0011, 4'b0010, 4'b0001, 0};  // last on non-owner ignored
      tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 0};

      all_idle();
      models_reset();
      #2;
      compare_all();
      #10 rst = 1'b0;

      // Free-running rotation on A (N=4), C (N=3), D (N=2), all requesting.
      req_a = 4'b1111; req_c = 3'b111; req_d = 2'b11;
      for (int i = 0; i < 7; i++) begin
         tick();
         check("rot4.idx", 32'(idx_a), 32'(i % 4));
         check("rot4.grant", 32'(grant_a), 32'(1) << (i % 4));
         check("rot3.idx", 32'(idx_c), 32'(i % 3));
         check("rot3.ptr_lt_n", 32'(u_c.ptr_q < 2'd3), 32'd1);
         check("rot2.idx", 32'(idx_d), 32'(i % 2));
         req_a = 4'b1111;
      end
      all_idle();
      tick();

      // Table-driven locked sequence on B.
      for (int i = 0; i < 16; i++) begin
         req_b  = tbl[i].req;
         last_b = tbl[i].last;
         tick();
         check("tbl.grant", 32'(grant_b), 32'(tbl[i].g));
         check("tbl.idx",   32'(idx_b),   32'(tbl[i].idx));
      end

      // Bring B to ptr=3, then requester 1 alone with last every cycle: no gaps.
      req_b = 4'b0100; last_b = 4'b0100; tick();
      req_b = 4'b0000; last_b = 4'b0000; tick();
      req_b = 4'b0010; last_b = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("regrant.grant", 32'(grant_b), 32'h2);
         check("regrant.valid", 32'(gv_b), 32'd1);
      end
      all_idle();
      tick();

      // Asynchronous reset in the middle of a locked transfer.
      req_b = 4'b1111;
      tick();
      tick();
      #3 rst = 1'b1;
      #1;
      check("arst.grant", 32'(grant_b), 32'h0);
      check("arst.valid", 32'(gv_b), 32'h0);
      check("arst.idx",   32'(idx_b), 32'h0);
      models_reset();
      compare_all();
      req_b = 4'b0110;
      #2 rst = 1'b0;
      tick();
      check("post_rst.grant", 32'(grant_b), 32'h2);
      all_idle();
      tick();

      // Random traffic against the reference model.
      for (int i = 0; i < 500; i++) begin
         req_a  = 4'($urandom);  last_a = 4'($urandom & $urandom);
         req_b  = 4'($urandom);  last_b = 4'($urandom & $urandom);
         req_c  = 3'($urandom);  last_c = 3'($urandom);
         req_d  = 2'($urandom);  last_d = 2'($urandom);
         if ($urandom_range(0, 3) == 0) req_b = req_b | 4'b1111;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
